// File: rtl/m_axis_cq_dispatch.sv
// Purpose: demultiplex completer-request TLPs to N_SINKS consumers by BAR id; unmapped BARs are drained and counted.
// Latency: zero; data/keep/last/user pass straight through, only the routing decision is registered per packet.
// Backpressure: s_tready follows the selected sink's m_tready only; dropped packets are always accepted.
module m_axis_cq_dispatch #(
    parameter int          DATA_WIDTH = 256,
    parameter int          KEEP_WIDTH = DATA_WIDTH/8,
    parameter int          N_SINKS    = 2,
    parameter logic [23:0] BAR_MAP    = 24'hFFFFF8
) (
    input  logic                          user_clk,
    input  logic                          user_reset,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_tkeep,
    input  logic                          s_tlast,
    input  logic [84:0]                   s_tuser,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [N_SINKS*DATA_WIDTH-1:0] m_tdata,
    output logic [N_SINKS*KEEP_WIDTH-1:0] m_tkeep,
    output logic [N_SINKS-1:0]            m_tlast,
    output logic [N_SINKS*85-1:0]         m_tuser,
    output logic [N_SINKS-1:0]            m_tvalid,
    input  logic [N_SINKS-1:0]            m_tready,
    output logic [15:0]                   drop_count,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sel, sel_nxt;
    logic [2:0]  bar_id;
    logic [2:0]  dsel;
    logic        dsel_ok;
    logic        drop_inc;

    assign m_tdata = {N_SINKS{s_tdata}};
    assign m_tkeep = {N_SINKS{s_tkeep}};
    assign m_tlast = {N_SINKS{s_tlast}};
    assign m_tuser = {N_SINKS{s_tuser}};
    assign busy    = (state != IDLE);

    // First-beat decode; later beats of a packet ignore tuser and use the locked sel.
    assign bar_id  = s_tuser[8:6];
    assign dsel    = 3'(BAR_MAP >> (3 * bar_id));
    assign dsel_ok = (int'(dsel) < N_SINKS);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        s_tready  = 1'b0;
        m_tvalid  = '0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (dsel_ok) begin
                    for (int i = 0; i < N_SINKS; i++) begin
                        if (dsel == 3'(i)) begin
                            m_tvalid[i] = s_tvalid;
                            s_tready    = m_tready[i];
                        end
                    end
                    if (s_tvalid && s_tready && !s_tlast) begin
                        sel_nxt   = dsel[1:0];
                        state_nxt = ROUTE;
                    end
                end else begin
                    s_tready = 1'b1;
                    if (s_tvalid) begin
                        drop_inc = 1'b1;
                        if (!s_tlast) state_nxt = DROP;
                    end
                end
            end
            ROUTE: begin
                for (int i = 0; i < N_SINKS; i++) begin
                    if (sel == 2'(i)) begin
                        m_tvalid[i] = s_tvalid;
                        s_tready    = m_tready[i];
                    end
                end
                if (s_tvalid && s_tready && s_tlast) state_nxt = IDLE;
            end
            DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing is offered or accepted while reset is held.
        if (user_reset) begin
            s_tready = 1'b0;
            m_tvalid = '0;
            drop_inc = 1'b0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state      <= IDLE;
            sel        <= 2'd0;
            drop_count <= 16'd0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_m_axis_cq_dispatch.sv
// Directed bench for m_axis_cq_dispatch: scoreboard of routed beats checked at each sink handshake.
module tb_m_axis_cq_dispatch;

    localparam int DW = 64;
    localparam int KW = DW/8;
    localparam int NS = 2;

    logic              user_clk;
    logic              user_reset;
    logic [DW-1:0]     s_tdata;
    logic [KW-1:0]     s_tkeep;
    logic              s_tlast;
    logic [84:0]       s_tuser;
    logic              s_tvalid;
    logic              s_tready;
    logic [NS*DW-1:0]  m_tdata;
    logic [NS*KW-1:0]  m_tkeep;
    logic [NS-1:0]     m_tlast;
    logic [NS*85-1:0]  m_tuser;
    logic [NS-1:0]     m_tvalid;
    logic [NS-1:0]     m_tready;
    logic [15:0]       drop_count;
    logic              busy;

    typedef struct {
        logic [1:0]    sink;
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // bar0 -> sink0, bar1 -> sink1, all other BARs dropped
    m_axis_cq_dispatch #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .N_SINKS    (NS),
        .BAR_MAP    (24'hFFFFC8)
    ) dut (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [84:0] mk_user(input logic [2:0] bar, input logic [3:0] typ);
        logic [84:0] u;
        u      = '0;
        u[8:6] = bar;
        u[5:2] = typ;
        return u;
    endfunction

    // Drive one beat, wait (bounded) for acceptance; exp_sink < 0 means the beat must be drained.
    task automatic send_beat(input logic [DW-1:0] d, input logic [2:0] bar, input logic [3:0] typ,
                             input logic last, input int exp_sink, output int waited);
        logic [NS-1:0] exp_v;
        exp_v    = (exp_sink < 0) ? '0 : NS'(1 << exp_sink);
        s_tdata  = d;
        s_tkeep  = '1;
        s_tlast  = last;
        s_tuser  = mk_user(bar, typ);
        s_tvalid = 1'b1;
        if (exp_sink >= 0) sb.push_back('{sink: exp_sink[1:0], dat: d, last: last});
        waited = 0;
        @(negedge user_clk);
        while (!s_tready && waited < 20) begin
            chk("held_valid", 64'(m_tvalid), 64'(exp_v));
            waited++;
            @(negedge user_clk);
        end
        chk("accept", 64'(s_tready), 64'd1);
        chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
        @(posedge user_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    always @(negedge user_clk) begin
        for (int i = 0; i < NS; i++) begin
            if (m_tvalid[i] && m_tready[i]) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sink", 64'(i), 64'(e.sink));
                    chk("data", m_tdata[i*DW +: DW], e.dat);
                    chk("last", 64'(m_tlast[i]), 64'(e.last));
                end
            end
        end
    end

    initial begin
        int w0, w1, w2;
        logic [4:0] pat;

        user_reset = 1'b1;
        m_tready   = 2'b11;
        s_tdata    = 64'h1111;
        s_tkeep    = '1;
        s_tlast    = 1'b0;
        s_tuser    = mk_user(3'd0, 4'd1);
        s_tvalid   = 1'b1;
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        s_tvalid   = 1'b0;

        // 3-beat MWr to bar0 -> sink0 only
        send_beat(64'hA000_0001, 3'd0, 4'd1, 1'b0, 0, w0);
        send_beat(64'hA000_0002, 3'd0, 4'd1, 1'b0, 0, w0);
        send_beat(64'hA000_0003, 3'd0, 4'd1, 1'b1, 0, w0);
        chk("t1_busy_after", 64'(busy), 64'd0);

        // 1-beat MRd to bar1 then 2-beat MWr to bar0, back-to-back
        send_beat(64'hB000_0001, 3'd1, 4'd0, 1'b1, 1, w0);
        send_beat(64'hB000_0002, 3'd0, 4'd1, 1'b0, 0, w1);
        send_beat(64'hB000_0003, 3'd0, 4'd1, 1'b1, 0, w2);
        chk("b2b_wait0", 64'(w0), 64'd0);
        chk("b2b_wait1", 64'(w1), 64'd0);
        chk("b2b_wait2", 64'(w2), 64'd0);

        // 4-beat packet to unmapped bar3
        send_beat(64'hC000_0001, 3'd3, 4'd1, 1'b0, -1, w0);
        chk("drop_wait", 64'(w0), 64'd0);
        chk("drop_cnt_1", 64'(drop_count), 64'd1);
        chk("drop_busy1", 64'(busy), 64'd1);
        send_beat(64'hC000_0002, 3'd0, 4'd1, 1'b0, -1, w0);
        chk("drop_busy2", 64'(busy), 64'd1);
        send_beat(64'hC000_0003, 3'd1, 4'd1, 1'b0, -1, w0);
        chk("drop_busy3", 64'(busy), 64'd1);
        send_beat(64'hC000_0004, 3'd3, 4'd1, 1'b1, -1, w0);
        chk("drop_busy4", 64'(busy), 64'd0);
        chk("drop_cnt_end", 64'(drop_count), 64'd1);

        // sink0 backpressure 1,0,0,1,1 with sink1 never ready
        pat      = 5'b11001;
        m_tready = 2'b00;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    m_tready[0] = pat[i];
                    @(posedge user_clk);
                    #1;
                end
                m_tready = 2'b11;
            end
            begin
                send_beat(64'hD000_0001, 3'd0, 4'd1, 1'b0, 0, w0);
                send_beat(64'hD000_0002, 3'd0, 4'd1, 1'b0, 0, w1);
                send_beat(64'hD000_0003, 3'd0, 4'd1, 1'b1, 0, w2);
            end
        join
        chk("bp_wait0", 64'(w0), 64'd0);
        chk("bp_wait1", 64'(w1), 64'd2);
        chk("bp_wait2", 64'(w2), 64'd0);

        // reset on beat 2 of a bar0 packet; remainder decoded as a fresh packet
        send_beat(64'hE000_0001, 3'd0, 4'd1, 1'b0, 0, w0);
        chk("mid_busy", 64'(busy), 64'd1);
        s_tdata    = 64'hE000_0002;
        s_tlast    = 1'b0;
        s_tuser    = mk_user(3'd0, 4'd1);
        s_tvalid   = 1'b1;
        user_reset = 1'b1;
        @(negedge user_clk);
        chk("mid_rst_ready", 64'(s_tready), 64'd0);
        chk("mid_rst_valid", 64'(m_tvalid), 64'd0);
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        s_tvalid   = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_drops", 64'(drop_count), 64'd0);
        send_beat(64'hE000_0003, 3'd3, 4'd1, 1'b0, -1, w0);
        chk("trunc_drop_cnt", 64'(drop_count), 64'd1);
        chk("trunc_busy", 64'(busy), 64'd1);
        send_beat(64'hE000_0004, 3'd0, 4'd1, 1'b1, -1, w0);
        chk("trunc_idle", 64'(busy), 64'd0);

        // saturation: stream single-beat drops up to 0xFFFE, then three more
        user_reset = 1'b1;
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        s_tuser    = mk_user(3'd3, 4'd0);
        s_tlast    = 1'b1;
        s_tvalid   = 1'b1;
        repeat (65534) @(posedge user_clk);
        #1;
        s_tvalid = 1'b0;
        chk("sat_pre", 64'(drop_count), 64'hFFFE);
        send_beat(64'hF000_0001, 3'd3, 4'd0, 1'b1, -1, w0);
        chk("sat_1", 64'(drop_count), 64'hFFFF);
        send_beat(64'hF000_0002, 3'd5, 4'd0, 1'b1, -1, w0);
        chk("sat_2", 64'(drop_count), 64'hFFFF);
        send_beat(64'hF000_0003, 3'd7, 4'd0, 1'b1, -1, w0);
        chk("sat_3", 64'(drop_count), 64'hFFFF);

        repeat (3) @(posedge user_clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
